// File: rtl/svc_sram_pattern_tester.sv
// SRAM pattern tester: writes an address-derived pattern over a range and then reads it back
// with pipelined reads, checking data, meta and last on every response.
module svc_sram_pattern_tester #(
  parameter int unsigned SRAM_ADDR_WIDTH = 8,
  parameter int unsigned SRAM_DATA_WIDTH = 16,
  parameter int unsigned SRAM_STRB_WIDTH = SRAM_DATA_WIDTH / 8,
  parameter int unsigned SRAM_META_WIDTH = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ERR_CNT_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [SRAM_ADDR_WIDTH-1:0] base_addr,
  input  logic [SRAM_ADDR_WIDTH:0]   count,
  input  logic [SRAM_DATA_WIDTH-1:0] seed,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [ERR_CNT_WIDTH-1:0]   err_cnt,
  output logic [SRAM_ADDR_WIDTH-1:0] first_err_addr,
  output logic                       sram_cmd_valid,
  input  logic                       sram_cmd_ready,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_cmd_addr,
  output logic [SRAM_META_WIDTH-1:0] sram_cmd_meta,
  output logic                       sram_cmd_last,
  output logic                       sram_cmd_wr_en,
  output logic [SRAM_DATA_WIDTH-1:0] sram_cmd_wr_data,
  output logic [SRAM_STRB_WIDTH-1:0] sram_cmd_wr_strb,
  input  logic                       sram_rd_resp_valid,
  output logic                       sram_rd_resp_ready,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_resp_data,
  input  logic [SRAM_META_WIDTH-1:0] sram_rd_resp_meta,
  input  logic                       sram_rd_resp_last
);

  localparam int unsigned CW = SRAM_ADDR_WIDTH + 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                     state;
  logic [CW-1:0]              cnt_q;
  logic [CW-1:0]              cmd_idx;
  logic [CW-1:0]              chk_idx;
  logic [SRAM_ADDR_WIDTH-1:0] base_q;
  logic [SRAM_DATA_WIDTH-1:0] seed_q;
  logic [OW-1:0]              outstanding;

  logic                       cmd_hs_c;
  logic                       rd_hs_c;
  logic                       rsp_hs_c;
  logic                       rsp_err_c;
  logic                       last_cmd_c;
  logic                       next_last_c;
  logic                       rd_slot_c;
  logic [CW-1:0]              next_idx_c;
  logic [OW-1:0]              out_after_c;
  logic [SRAM_ADDR_WIDTH-1:0] next_addr_c;
  logic [SRAM_ADDR_WIDTH-1:0] chk_addr_c;

  // Handshakes, next-word fields and the expected response for check index chk_idx
  always_comb begin
    cmd_hs_c    = sram_cmd_valid && sram_cmd_ready;
    rd_hs_c     = cmd_hs_c && (state == S_READ);
    rsp_hs_c    = sram_rd_resp_valid && sram_rd_resp_ready && (outstanding != '0) &&
                  ((state == S_READ) || (state == S_DRAIN));
    last_cmd_c  = (cmd_idx == cnt_q - CW'(1));
    next_idx_c  = cmd_idx + CW'(1);
    next_last_c = (next_idx_c == cnt_q - CW'(1));
    next_addr_c = sram_cmd_addr + SRAM_ADDR_WIDTH'(1);
    out_after_c = outstanding + OW'(rd_hs_c) - OW'(rsp_hs_c);
    rd_slot_c   = (out_after_c < OW'(MAX_OUTSTANDING));
    chk_addr_c  = base_q + chk_idx[SRAM_ADDR_WIDTH-1:0];
    rsp_err_c   = (sram_rd_resp_data != (SRAM_DATA_WIDTH'(chk_addr_c) + seed_q)) ||
                  (sram_rd_resp_meta != SRAM_META_WIDTH'(chk_idx)) ||
                  (sram_rd_resp_last != (chk_idx == cnt_q - CW'(1)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      busy               <= 1'b0;
      done               <= 1'b0;
      pass               <= 1'b0;
      err_cnt            <= '0;
      first_err_addr     <= '0;
      sram_cmd_valid     <= 1'b0;
      sram_cmd_addr      <= '0;
      sram_cmd_meta      <= '0;
      sram_cmd_last      <= 1'b0;
      sram_cmd_wr_en     <= 1'b0;
      sram_cmd_wr_data   <= '0;
      sram_cmd_wr_strb   <= '0;
      sram_rd_resp_ready <= 1'b1;
      cnt_q              <= '0;
      cmd_idx            <= '0;
      chk_idx            <= '0;
      base_q             <= '0;
      seed_q             <= '0;
      outstanding        <= '0;
    end else begin
      done               <= 1'b0;
      sram_rd_resp_ready <= 1'b1;
      outstanding        <= out_after_c;

      if (rsp_hs_c) begin
        chk_idx <= chk_idx + CW'(1);
        if (rsp_err_c) begin
          if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
          if (err_cnt == '0) first_err_addr <= chk_addr_c;
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
            base_q         <= base_addr;
            seed_q         <= seed;
            cnt_q          <= count;
            cmd_idx        <= '0;
            chk_idx        <= '0;
            if (count == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state            <= S_WRITE;
              busy             <= 1'b1;
              sram_cmd_valid   <= 1'b1;
              sram_cmd_addr    <= base_addr;
              sram_cmd_meta    <= '0;
              sram_cmd_last    <= (count == CW'(1));
              sram_cmd_wr_en   <= 1'b1;
              sram_cmd_wr_data <= SRAM_DATA_WIDTH'(base_addr) + seed;
              sram_cmd_wr_strb <= '1;
            end
          end
        end
        S_WRITE: begin
          if (cmd_hs_c) begin
            if (last_cmd_c) begin
              // Nothing can be outstanding yet, so read 0 is presented straight away
              state            <= S_READ;
              cmd_idx          <= '0;
              sram_cmd_addr    <= base_q;
              sram_cmd_meta    <= '0;
              sram_cmd_last    <= (cnt_q == CW'(1));
              sram_cmd_wr_en   <= 1'b0;
              sram_cmd_wr_data <= '0;
              sram_cmd_wr_strb <= '0;
            end else begin
              cmd_idx          <= next_idx_c;
              sram_cmd_addr    <= next_addr_c;
              sram_cmd_meta    <= SRAM_META_WIDTH'(next_idx_c);
              sram_cmd_last    <= next_last_c;
              sram_cmd_wr_data <= SRAM_DATA_WIDTH'(next_addr_c) + seed_q;
            end
          end
        end
        S_READ: begin
          // Fields advance on every handshake; valid waits for a free outstanding slot
          if (cmd_hs_c) begin
            if (last_cmd_c) begin
              state          <= S_DRAIN;
              sram_cmd_valid <= 1'b0;
            end else begin
              cmd_idx        <= next_idx_c;
              sram_cmd_addr  <= next_addr_c;
              sram_cmd_meta  <= SRAM_META_WIDTH'(next_idx_c);
              sram_cmd_last  <= next_last_c;
              sram_cmd_valid <= rd_slot_c;
            end
          end else if (!sram_cmd_valid) begin
            sram_cmd_valid <= rd_slot_c;
          end
        end
        S_DRAIN: begin
          if (outstanding == '0) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt == '0);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
